// File: rtl/i2c_target_regs_pkg.sv
// i2c_target_regs shared types: FSM states, ACK/NAK levels,
// R/W bit position and default bus address.
package i2c_target_regs_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } state_e;

  localparam logic       I2C_ACK         = 1'b0;
  localparam logic       I2C_NAK         = 1'b1;
  localparam int         RW_BIT          = 0;
  localparam logic [6:0] DEF_TARGET_ADDR = 7'h27;

endpackage

// File: rtl/i2c_line_filter.sv
// 2-FF synchronizer for one I2C line; with I2C_TARGET_GLITCH_FILTER_EN
// the output only follows FILTER_LEN consecutive equal samples.
module i2c_line_filter
`ifdef I2C_TARGET_GLITCH_FILTER_EN
#(
  parameter int FILTER_LEN = 3
)
`endif
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_line
);

  logic [1:0] sync_q;

  // idle bus level is high
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], i_line};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (sync_q[1] != out_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) out_d = sync_q[1];
      else                              cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
      out_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign o_line = out_q;
`else
  assign o_line = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with pointer-addressed register file and sensor register.
// Optional input glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR   = DEF_TARGET_ADDR,
  parameter int         DATA_DEPTH    = 8,
  parameter int         REG_ADDR_BITS = 4,
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  parameter int         FILTER_LEN    = 3,
`endif
  parameter int         SENSOR_REG    = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_scl_in,
  input  logic                     i_sda_in,
  output logic                     o_sda_oe,
  output logic                     o_sda_out,
  input  logic [DATA_DEPTH-1:0]    i_sensor_bits,
  input  logic                     i_sensor_valid,
  output logic                     o_sensor_ready,
  output logic [REG_ADDR_BITS-1:0] o_wr_addr,
  output logic [DATA_DEPTH-1:0]    o_wr_data,
  output logic                     o_wr_valid,
  output logic                     o_busy
);

  localparam int NREGS = 2 ** REG_ADDR_BITS;
  localparam logic [REG_ADDR_BITS-1:0] SENS_IDX = REG_ADDR_BITS'(SENSOR_REG);

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start, stop;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
`else
  i2c_line_filter u_scl_filt (
`endif
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_line (i_scl_in),
    .o_line (scl_f)
  );

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
`else
  i2c_line_filter u_sda_filt (
`endif
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_line (i_sda_in),
    .o_line (sda_f)
  );

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [DATA_DEPTH-1:0]    shift_q, shift_d;
  logic [REG_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                     rw_q, rw_d;
  logic                     sda_oe_q, sda_oe_d;
  logic                     busy_q, busy_d;
  logic [REG_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_DEPTH-1:0]    wr_data_q, wr_data_d;
  logic                     wr_valid_q, wr_valid_d;
  logic                     rdy_q;
  logic [DATA_DEPTH-1:0]    regs_q [NREGS];
  logic [DATA_DEPTH-1:0]    regs_d [NREGS];

  logic [DATA_DEPTH-1:0]    byte_in;
  logic [REG_ADDR_BITS-1:0] ptr_inc;
  logic                     sens_ld;

  assign byte_in = {shift_q[DATA_DEPTH-2:0], sda_f};
  assign ptr_inc = ptr_q + 1'b1;
  assign sens_ld = i_sensor_valid & rdy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    regs_d     = regs_q;

    if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (byte_in[DATA_DEPTH-1:1] == TARGET_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = byte_in[RW_BIT];
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        // first fall asserts ACK, second fall ends it
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~I2C_ACK;
          end else if (rw_q) begin
            shift_d  = regs_q[ptr_q] << 1;
            sda_oe_d = ~regs_q[ptr_q][DATA_DEPTH-1];
            cnt_d    = 4'd1;
            state_d  = RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = PTR;
          end
        end
        PTR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            ptr_d   = byte_in[REG_ADDR_BITS-1:0];
            state_d = PTR_ACK;
          end
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~I2C_ACK;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WDATA;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = WDATA_ACK;
            ptr_d   = ptr_inc;
            if (ptr_q != SENS_IDX) begin
              regs_d[ptr_q] = byte_in;
              wr_addr_d     = ptr_q;
              wr_data_d     = byte_in;
              wr_valid_d    = 1'b1;
            end
          end
        end
        RDATA: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = RACK;
          end else begin
            sda_oe_d = ~shift_q[DATA_DEPTH-1];
            shift_d  = shift_q << 1;
            cnt_d    = cnt_q + 1'b1;
          end
        end
        RACK: if (scl_rise) begin
          ptr_d = ptr_inc;
          if (sda_f == I2C_NAK) begin
            state_d = IDLE;
          end else begin
            shift_d = regs_q[ptr_inc];
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // applied last so a sensor load beats a same-cycle bus write
    if (sens_ld) regs_d[SENS_IDX] = i_sensor_bits;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      rdy_q      <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      scl_q      <= scl_f;
      sda_q      <= sda_f;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rdy_q      <= 1'b1;
      regs_q     <= regs_d;
    end
  end

  assign o_sda_oe       = sda_oe_q;
  assign o_sda_out      = 1'b0;
  assign o_sensor_ready = rdy_q;
  assign o_wr_addr      = wr_addr_q;
  assign o_wr_data      = wr_data_q;
  assign o_wr_valid     = wr_valid_q;
  assign o_busy         = busy_q;

endmodule
